// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Optional checksum support is controlled by INSTR_MEM_LOADER_CHECKSUM_EN.
package instr_mem_pkg;

  localparam int unsigned IMEM_DEPTH  = 256;
  localparam int unsigned IMEM_WORD_W = 32;
  localparam int unsigned IMEM_BYTE_W = 8;

  // CHECK is only entered when the checksum option is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CHECK = 3'd4
  } loader_state_e;

  // Byte address of a word index; wraps modulo 2^32.
  function automatic logic [IMEM_WORD_W-1:0] imem_byte_addr(
    input logic [IMEM_WORD_W-1:0] base,
    input logic [IMEM_WORD_W-1:0] idx
  );
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into big-endian 32-bit words.
// word_valid_o pulses combinationally with the 4th accepted byte; word_o is
// the completed word in that same cycle (first byte in [31:24]).
module byte_word_packer
  import instr_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   byte_valid_i,
  input  logic [IMEM_BYTE_W-1:0] byte_i,
  output logic                   word_valid_o,
  output logic [IMEM_WORD_W-1:0] word_o
);

  logic [1:0]                         byte_cnt_q, byte_cnt_d;
  logic [IMEM_WORD_W-IMEM_BYTE_W-1:0] shift_q, shift_d;

  // Shift and count on each accepted byte; the count wraps to 0 after byte 4.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (byte_valid_i) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[IMEM_WORD_W-2*IMEM_BYTE_W-1:0], byte_i};
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Completed word is presented alongside the 4th byte.
  always_comb begin
    word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 2'd3);
    word_o       = {shift_q, byte_i};
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: byte stream in, one-cycle word writes out,
// core held in reset while loading.
// Define INSTR_MEM_LOADER_CHECKSUM_EN to require a trailing 32-bit
// big-endian checksum (sum mod 2^32 of all written words).
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_words,
  input  logic                   in_valid,
  input  logic [IMEM_BYTE_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [IMEM_WORD_W-1:0] mem_addr,
  output logic [IMEM_WORD_W-1:0] mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   cpu_hold,
  output logic                   error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  loader_state_e          state_q;
  logic [CNT_W-1:0]       n_q;
  logic [CNT_W-1:0]       word_idx_q;
  logic                   mem_we_q;
  logic [IMEM_WORD_W-1:0] mem_addr_q;
  logic [IMEM_WORD_W-1:0] mem_wdata_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   cpu_hold_q;
  logic                   error_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [IMEM_WORD_W-1:0] sum_q;
`endif

  logic                   start_ok;
  logic                   overflow_d;
  logic [CNT_W-1:0]       n_d;
  logic [CNT_W-1:0]       word_idx_d;
  logic                   accept;
  logic                   word_valid;
  logic [IMEM_WORD_W-1:0] word;

  // in_ready is a pure decode of state so it drops the cycle after byte 4.
  always_comb begin
    in_ready = (state_q == LOAD);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    if (state_q == CHECK) in_ready = 1'b1;
`endif
  end

  // Start qualification, clamped word count and next word index.
  always_comb begin
    start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
    overflow_d = (num_words > DEPTH_C);
    n_d        = overflow_d ? DEPTH_C : num_words;
    word_idx_d = word_idx_q + CNT_W'(1);
    accept     = in_valid && in_ready;
  end

  byte_word_packer u_packer (
    .clk          (clk),
    .rst_n        (reset_n),
    .clear_i      (start_ok),
    .byte_valid_i (accept),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      word_idx_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_hold_q  <= 1'b1;
      error_q     <= 1'b0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            n_q        <= n_d;
            word_idx_q <= '0;
            error_q    <= overflow_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
            if (n_d == '0) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= LOAD;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              cpu_hold_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            state_q     <= WRITE;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= imem_byte_addr(BASE_ADDR, IMEM_WORD_W'(word_idx_q));
            mem_wdata_q <= word;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_q + word;
`endif
          end
        end
        WRITE: begin
          word_idx_q <= word_idx_d;
          if (word_idx_d == n_q) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            state_q    <= CHECK;
`else
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
`endif
          end else begin
            state_q <= LOAD;
          end
        end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (word_valid) begin
            if (word != sum_q) error_q <= 1'b1;
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered outputs to ports.
  always_comb begin
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    busy      = busy_q;
    done      = done_q;
    cpu_hold  = cpu_hold_q;
    error     = error_q;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader. Expected writes come from a
// queue model built from the byte stream; a negedge monitor checks every
// write, and directed literals pin the model.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [8:0]  num_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic        error;

  instr_mem_loader #(
    .DEPTH     (256),
    .BASE_ADDR (32'h0000_0000),
    .CNT_W     (9)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [7:0]  bytes_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int unsigned exp_n;
  logic        exp_err;
  logic [31:0] model_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every write must match the head of the model queue and occur with
  // in_ready low and the core held.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        chk("write_addr", mem_addr, exp_addr_q.pop_front());
        chk("write_data", mem_wdata, exp_data_q.pop_front());
      end
      chk("in_ready_in_write", 32'(in_ready), 32'd0);
      chk("cpu_hold_in_write", 32'(cpu_hold), 32'd1);
      chk("busy_in_write", 32'(busy), 32'd1);
    end
  end

  task automatic check_reset_vals(input string p);
    chk({p, "_in_ready"},  32'(in_ready),  32'd0);
    chk({p, "_mem_we"},    32'(mem_we),    32'd0);
    chk({p, "_mem_addr"},  mem_addr,       32'd0);
    chk({p, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({p, "_busy"},      32'(busy),      32'd0);
    chk({p, "_done"},      32'(done),      32'd0);
    chk({p, "_cpu_hold"},  32'(cpu_hold),  32'd1);
    chk({p, "_error"},     32'(error),     32'd0);
  endtask

  // Build the expected write list from bytes_q, then pulse start.
  task automatic begin_load(input int unsigned n);
    int unsigned eff;
    logic [31:0] w;
    eff = (n > DEPTH) ? DEPTH : n;
    exp_addr_q.delete();
    exp_data_q.delete();
    obs_addr.delete();
    obs_data.delete();
    model_sum = '0;
    for (int unsigned i = 0; i < eff; i++) begin
      w = {bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]};
      exp_addr_q.push_back(BASE + 32'(4 * i));
      exp_data_q.push_back(w);
      model_sum = model_sum + w;
    end
    exp_n   = eff;
    exp_err = (n > DEPTH);
    start = 1'b1;
    num_words = 9'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (eff == 0) begin
      chk("zero_done_next_cycle", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
    end else begin
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("start_done_cleared", 32'(done), 32'd0);
    end
    chk("start_error", 32'(error), 32'(exp_err));
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      if (gap > 0) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_range(input int unsigned lo, input int unsigned hi, input int unsigned gap);
    for (int unsigned i = lo; i < hi; i++) send_byte(bytes_q[i], gap);
    in_valid = 1'b0;
  endtask

  // Optionally send the checksum, wait for done, check final status.
  task automatic finish_load(input logic [31:0] cks_delta);
    int unsigned t;
    logic        err_final;
    logic [31:0] cks;
    err_final = exp_err;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    if (exp_n > 0) begin
      cks = model_sum + cks_delta;
      send_byte(cks[31:24], 0);
      send_byte(cks[23:16], 0);
      send_byte(cks[15:8], 0);
      send_byte(cks[7:0], 0);
      in_valid = 1'b0;
      if (cks_delta != 0) err_final = 1'b1;
    end
`else
    cks = cks_delta;
`endif
    t = 0;
    @(negedge clk);
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("done_error", 32'(error), 32'(err_final));
    chk("missing_writes", 32'(exp_addr_q.size()), 32'd0);
    chk("write_count", 32'(obs_addr.size()), 32'(exp_n));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    num_words = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_rst");

    // Two words, in_valid held high.
    bytes_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    begin_load(2);
    send_range(0, 8, 0);
    finish_load(32'd0);
    if (obs_addr.size() == 2) begin
      chk("t1_addr0", obs_addr[0], 32'h0000_0000);
      chk("t1_data0", obs_data[0], 32'h8C01_0004);
      chk("t1_addr1", obs_addr[1], 32'h0000_0004);
      chk("t1_data1", obs_data[1], 32'h0022_1820);
    end else begin
      chk("t1_write_count", 32'(obs_addr.size()), 32'd2);
    end

    // Same bytes with 3-cycle gaps.
    begin_load(2);
    send_range(0, 8, 3);
    finish_load(32'd0);
    if (obs_data.size() == 2) chk("gap_data1", obs_data[1], 32'h0022_1820);

    // Zero words.
    begin_load(0);
    finish_load(32'd0);

    // Overflow: 300 requested, 256 written.
    bytes_q.delete();
    for (int unsigned j = 0; j < 4 * DEPTH; j++) bytes_q.push_back(8'(j * 37 + (j >> 2)));
    begin_load(300);
    send_range(0, 4 * DEPTH, 0);
    finish_load(32'd0);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_count", 32'(obs_addr.size()), 32'd256);
    if (obs_addr.size() > 0) chk("ovf_last_addr", obs_addr[obs_addr.size()-1], 32'h0000_03FC);

    // start while busy is ignored.
    bytes_q.delete();
    for (int unsigned j = 0; j < 12; j++) bytes_q.push_back(8'(8'hA0 + j));
    begin_load(3);
    send_range(0, 6, 0);
    start = 1'b1;
    num_words = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 32'd1);
    send_range(6, 12, 0);
    finish_load(32'd0);
    if (obs_addr.size() == 3) begin
      chk("sb_addr2", obs_addr[2], 32'h0000_0008);
      chk("sb_data1", obs_data[1], 32'hA4A5_A6A7);
    end

    // Reset after 6 bytes of a 4-word load, then a fresh 1-word load.
    bytes_q.delete();
    for (int unsigned j = 0; j < 16; j++) bytes_q.push_back(8'(8'h50 + j));
    begin_load(4);
    send_range(0, 6, 0);
    chk("mid_writes_before_reset", 32'(obs_addr.size()), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    begin_load(1);
    send_range(0, 4, 0);
    finish_load(32'd0);
    if (obs_addr.size() == 1) begin
      chk("rl_addr", obs_addr[0], 32'h0000_0000);
      chk("rl_data", obs_data[0], 32'h1122_3344);
    end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    // Checksum good (bytes 00,00,00,03) then bad (00,00,00,04).
    bytes_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    begin_load(2);
    send_range(0, 8, 0);
    finish_load(32'd0);
    chk("cks_good_error", 32'(error), 32'd0);
    begin_load(2);
    send_range(0, 8, 0);
    finish_load(32'd1);
    chk("cks_bad_error", 32'(error), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
